// File: rtl/fifo_rd_stream_pkg.sv
// Shared async-FIFO definitions: read-stage occupancy encoding and default word width.
package fifo_rd_stream_pkg;

    localparam int unsigned DSIZE_DEF = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the async FIFO into a 2-entry buffer and presents it
// as a valid/ready stream so memory read timing is decoupled from m_ready.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rflush,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [CNTW-1:0]  rcount
);

    occ_e             state_q;
    logic             m_valid_q;
    logic [DSIZE-1:0] e0_q;
    logic [DSIZE-1:0] e1_q;
    logic [CNTW-1:0]  rcount_q;

    logic push;
    logic pop;

    // Pop request depends only on registered occupancy, never on m_ready.
    assign rinc = rrst_n & ~rempty & ~rflush & (state_q != ST_TWO);
    assign push = rinc;
    assign pop  = m_valid_q & m_ready;

    assign m_valid = m_valid_q;
    assign m_data  = e0_q;
    assign rcount  = rcount_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
            e0_q      <= '0;
            e1_q      <= '0;
            rcount_q  <= '0;
        end else begin
            if (pop) begin
                rcount_q <= rcount_q + CNTW'(1);
            end
            // Flush drops buffered words only; entry contents are simply abandoned.
            if (rflush) begin
                state_q   <= ST_EMPTY;
                m_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (push) begin
                            state_q   <= ST_ONE;
                            m_valid_q <= 1'b1;
                            e0_q      <= rdata;
                        end
                    end
                    ST_ONE: begin
                        if (push && !pop) begin
                            state_q <= ST_TWO;
                            e1_q    <= rdata;
                        end else if (push) begin
                            e0_q <= rdata;
                        end else if (pop) begin
                            state_q   <= ST_EMPTY;
                            m_valid_q <= 1'b0;
                        end
                    end
                    ST_TWO: begin
                        if (pop) begin
                            state_q <= ST_ONE;
                            e0_q    <= e1_q;
                        end
                    end
                    default: begin
                        state_q   <= ST_EMPTY;
                        m_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed scenarios plus random traffic against a
// queue-based model of the FIFO source and the 2-deep output buffer.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;

    logic          rclk;
    logic          rrst_n;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rflush;
    logic          m_ready;
    logic          rinc, rinc4;
    logic          m_valid, m_valid4;
    logic [DW-1:0] m_data, m_data4;
    logic [15:0]   rcount;
    logic [3:0]    rcount4;

    fifo_rd_stream #(.DSIZE(DW), .CNTW(16)) u_dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
        .rflush(rflush), .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .rcount(rcount)
    );

    fifo_rd_stream #(.DSIZE(DW), .CNTW(4)) u_dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
        .rflush(rflush), .rinc(rinc4), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .rcount(rcount4)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;

    logic [DW-1:0] src[$];
    logic [DW-1:0] obuf[$];
    logic [DW-1:0] last_head;
    int unsigned   cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        obuf.delete();
        last_head = '0;
        cnt = 0;
    endtask

    // One rclk cycle: drive at negedge, check, then advance the model at posedge.
    task automatic step(input logic fl, input logic rdy, input logic hold);
        logic          exp_rinc;
        logic          exp_valid;
        logic          push, pop;
        logic [DW-1:0] w;
        @(negedge rclk);
        rflush  = fl;
        m_ready = rdy;
        rempty  = (src.size() == 0) || hold;
        rdata   = (src.size() != 0) ? src[0] : DW'($urandom);
        #1;
        exp_valid = rrst_n && (obuf.size() != 0);
        exp_rinc  = rrst_n && !rempty && !fl && (obuf.size() < 2);
        check("rinc", 32'(rinc), 32'(exp_rinc));
        check("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid)
            check("m_data", 32'(m_data), 32'(obuf[0]));
        else if (!rrst_n)
            check("m_data_rst", 32'(m_data), 32'(0));
        check("rcount", 32'(rcount), 32'(16'(cnt)));
        check("rcount4", 32'(rcount4), 32'(4'(cnt)));
        push = exp_rinc;
        pop  = exp_valid && rdy;
        @(posedge rclk);
        if (rrst_n) begin
            w = '0;
            if (push) w = src.pop_front();
            if (pop) begin
                cnt++;
                void'(obuf.pop_front());
            end
            if (fl) obuf.delete();
            else if (push) obuf.push_back(w);
            if (obuf.size() != 0) last_head = obuf[0];
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rrst_n = 1'b0;
        #1;
        check("rst_valid", 32'(m_valid), 32'(0));
        check("rst_data", 32'(m_data), 32'(0));
        check("rst_rinc", 32'(rinc), 32'(0));
        check("rst_count", 32'(rcount), 32'(0));
        model_clear();
        step(1'b0, 1'b0, 1'b0);
        #2;
        rrst_n = 1'b1;
    endtask

    initial begin
        rrst_n  = 1'b0;
        rempty  = 1'b1;
        rdata   = '0;
        rflush  = 1'b0;
        m_ready = 1'b0;
        model_clear();

        // Reset hold with data pending, then first push after release.
        src.push_back(8'hA5);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #2;
        rrst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Streaming 0x01..0x08.
        do_reset();
        src.delete();
        for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0);
        check("stream_cnt", 32'(rcount), 32'(8));
        check("stream_empty", 32'(m_valid), 32'(0));

        // Backpressure then release.
        do_reset();
        src = '{8'h10, 8'h11, 8'h12};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check("bp_data", 32'(m_data), 32'(8'h10));
        check("bp_left", 32'(src.size()), 32'(1));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);

        // Coincident push/pop while holding one word.
        do_reset();
        src = '{8'h20, 8'h21};
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("simul_data", 32'(m_data), 32'(8'h21));

        // Flush from TWO: next delivered is the FIFO's next unread word.
        do_reset();
        src = '{8'h30, 8'h31, 8'h32, 8'h33};
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("flush_next", 32'(m_data), 32'(8'h32));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

        // Counter wrap on the 4-bit instance.
        do_reset();
        src.delete();
        for (int i = 0; i < 17; i++) src.push_back(DW'($urandom));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        check("wrap4", 32'(rcount4), 32'(1));
        check("wrap16", 32'(rcount), 32'(17));

        // Random traffic with occasional flush, stalls and mid-run reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 5 && $urandom_range(0, 2) == 0)
                src.push_back(DW'($urandom));
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
